// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues single-cycle fetches to instructfetch and
// buffers returned {instr, pc} pairs in a small FIFO toward decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [31:0]               pc_o,
    output logic                      fetch_en_o,
    input  logic [31:0]               instr_i,
    input  logic                      redirect_i,
    input  logic [31:0]               redirect_pc_i,
    input  logic                      halt_i,
    output logic                      valid_o,
    output logic [31:0]               instr_o,
    output logic [31:0]               instr_pc_o,
    input  logic                      ready_i,
    output logic [$clog2(QDEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc_q;
    logic          inflight_q;
    logic [31:0]   inflight_pc_q;
    entry_t        mem [QDEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          issue;
    logic          push;
    logic          pop;
    logic          redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc_i[1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Issue only when the buffer can absorb every fetch already committed to it.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: state_nxt = RUN;
            RUN: begin
                if (halt_i) state_nxt = HALT;
                issue = !halt_i && !redirect_i &&
                        ((SW'(count_q) + SW'(inflight_q)) < SW'(QDEPTH));
            end
            HALT: begin
                if (!halt_i) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A redirect kills the fetch whose data returns this cycle.
    assign push = inflight_q && !redirect_i;
    assign pop  = valid_o && ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
        end else begin
            if (redirect_i)  pc_q <= {redirect_pc_i[31:2], 2'b00};
            else if (issue)  pc_q <= pc_q + 32'd4;
            inflight_q    <= issue;
            inflight_pc_q <= pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array carries no reset; contents are masked by count_q.
    always_ff @(posedge clk) begin
        if (push && !reset) mem[tail_q] <= '{instr: instr_i, pc: inflight_pc_q};
    end

    assign pc_o       = pc_q;
    assign fetch_en_o = issue;
    assign count_o    = count_q;
    assign valid_o    = (count_q != '0);
    assign instr_o    = valid_o ? mem[head_q].instr : 32'h0;
    assign instr_pc_o = valid_o ? mem[head_q].pc    : 32'h0;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push && (count_q == CW'(QDEPTH))));

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the front end of the out-of-order core. It owns the program counter and drives the address port of `instructfetch`. It tracks the single-cycle in-flight fetch and buffers returned instructions, tagged with their PC, in a small FIFO that feeds decode through a valid/ready handshake. It also implements pipeline redirect (branch mispredict / exception), which flushes the buffer and any in-flight fetch, and a halt input that stops issuing fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `QDEPTH`, 4, instruction buffer depth in entries; power of two, 2..16.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `pc_o`  out  32  address presented to `instructfetch` (its `pc_i`).
- `fetch_en_o`  out  1  high in the cycle a fetch is issued at `pc_o`.
- `instr_i`  in  32  `instructfetch` output (its `instr_o`), valid one cycle after issue.
- `redirect_i`  in  1  flush-and-redirect request.
- `redirect_pc_i`  in  32  new PC; bits [1:0] ignored (forced to 0).
- `halt_i`  in  1  level; suppresses new fetch issue while high.
- `valid_o`  out  1  buffer head valid toward decode.
- `instr_o`  out  32  buffer head instruction.
- `instr_pc_o`  out  32  PC of buffer head instruction.
- `ready_i`  in  1  decode accepts head when `valid_o && ready_i`.
- `count_o`  out  $clog2(QDEPTH)+1  current buffer occupancy.

## Operation
- FSM states:
  - IDLE: entered on reset; no fetch issued; moves to RUN on the next cycle.
  - RUN: issue allowed.
  - HALT: no issue while `halt_i`=1; returns to RUN in the cycle after `halt_i` falls.
- RUN goes to HALT when `halt_i`=1. `redirect_i` is legal in every state and does not change the state, except that IDLE always proceeds to RUN.
- Issue rule, in RUN only: `fetch_en_o` = (`count_o` + `inflight`) < QDEPTH and no `redirect_i` this cycle.
  - `inflight` is 1 if a fetch was issued the previous cycle and not killed.
  - The rule uses current occupancy and ignores a same-cycle pop.
- On issue, `pc_o` advances by 4 next cycle, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0.
- Return: in the cycle after an issue, if not killed, {`instr_i`, issued PC} is written at the buffer tail.
- Buffer:
  - Circular FIFO with head/tail pointers.
  - Push and pop in the same cycle leave `count_o` unchanged. Pop when empty is impossible, since `valid_o`=0.
  - The issue rule guarantees a push never finds the buffer full; this is checked by assertion.
- Redirect in cycle N:
  - A pop handshaken in cycle N completes normally.
  - All remaining entries are discarded at end of N.
  - A fetch issued in N-1 is killed: its data returning in N is not written.
  - No fetch is issued in N.
  - `pc_o` = {`redirect_pc_i`[31:2],2'b00} in N+1.
- Redirect while halted updates the PC and flushes; issue resumes only after `halt_i` falls.
- A fetch already in flight when `halt_i` rises still lands in the buffer, and the buffer keeps draining.

## Timing
- Reset values:
  - `pc_o`=RESET_PC, `fetch_en_o`=0, `valid_o`=0, `count_o`=0.
  - `instr_o`=0 and `instr_pc_o`=0 while empty.
  - `inflight`=0, state IDLE.
  - Reset asserted mid-operation discards all buffer contents and the in-flight fetch in that same edge.
- First issue is in the 2nd cycle after reset deasserts (the IDLE cycle, then RUN).
- Fetch-to-buffer latency: issue at N, write at end of N+1, `valid_o`=1 in N+2 if the buffer was empty.
- Throughput: one instruction per cycle sustained with `ready_i`=1.
- `valid_o`, `instr_o`, `instr_pc_o` are driven from registered buffer state only, with no combinational path from `ready_i` or `instr_i`.
- Redirect-to-first-valid: redirect at N, issue at N+1 of the new PC, `valid_o` at N+3.

## Test plan
- Reset then free run with RESET_PC=0, `ready_i`=1 -> `pc_o` sequence 0,4,8,…; `instr_pc_o` 0,4,8 on consecutive cycles after the 3-cycle start-up; `count_o` ≤ 1.
- Backpressure with `ready_i`=0 and QDEPTH=4 -> exactly 4 issues, then `fetch_en_o`=0 and `count_o`=4. Raise `ready_i` -> entries drain in order 0,4,8,C and issue resumes at 16.
- Redirect to 32'h100 while the buffer holds 3 entries and a fetch is in flight -> buffer empties next cycle; the stale instruction is not written; `pc_o`=32'h100; first `instr_pc_o`=32'h100 three cycles after the redirect.
- Misaligned redirect to 32'h103 and PC wrap from 32'hFFFF_FFF8 -> `pc_o`=32'h100; sequence FFFF_FFF8, FFFF_FFFC, 0.
- `halt_i` pulse of 5 cycles with one fetch in flight -> in-flight instruction delivered; no issue during halt; issue resumes the cycle after `halt_i` falls with the next sequential PC.
- Reset asserted with a full buffer and simultaneous redirect -> next cycle `valid_o`=0, `count_o`=0, `pc_o`=RESET_PC, state IDLE.
